pb_adc_capture: RTL and testbench

- I2S receiver for the codec ADC path: samples AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT (codec is bit-clock and LR-clock master) in the 100 MHz CLK domain.
- Deserialises audio samples and buffers them in a first-word-fall-through FIFO.
- PicoBlaze port logic or the RAM writer pops samples from the FIFO.
- Counterpart of the codec DAC transmit path: captures recorded audio instead of driving playback.

---
 rtl/pb_adc_capture.sv | 257 +++++++++++++++++++++++++
 tb/tb_pb_adc_capture.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pb_adc_capture.sv
// pb_adc_capture: I2S receiver for the codec ADC path with a first-word-fall-through FIFO.
// The codec is the bit-clock and LR-clock master. Its signals are synchronised into CLK.
// Samples are deserialised MSB first and buffered for the PicoBlaze port logic or the RAM writer.
//
// Optional build macro PB_ADC_CAPTURE_STEREO_EN:
//   defined   - both channels are captured; each FIFO entry is {left, right}, 2*SAMPLE_W bits.
//   undefined - only the left channel is captured; each FIFO entry is SAMPLE_W bits.
//
// Ports:
//   CLK, pb_reset            system clock and asynchronous active-high reset
//   aud_bclk, aud_adclrck    codec bit clock and LR clock (asynchronous; lrck low = left)
//   aud_adcdat               codec serial data
//   enable                   capture enable (level)
//   pop                      single-cycle FIFO read acknowledge
//   clr_ovf                  clears the sticky overflow and frame_err flags
//   fifo_dout                head-of-FIFO sample
//   fifo_empty, fifo_full    FIFO status
//   fifo_count               number of stored entries
//   overflow                 sticky: a sample was dropped because the FIFO was full
//   frame_err                sticky: a short frame was detected
module pb_adc_capture #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic                 CLK,
  input  logic                 pb_reset,
  input  logic                 aud_bclk,
  input  logic                 aud_adclrck,
  input  logic                 aud_adcdat,
  input  logic                 enable,
  input  logic                 pop,
  input  logic                 clr_ovf,
`ifdef PB_ADC_CAPTURE_STEREO_EN
  output logic [2*SAMPLE_W-1:0] fifo_dout,
`else
  output logic [SAMPLE_W-1:0]   fifo_dout,
`endif
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow,
  output logic                 frame_err
);

`ifdef PB_ADC_CAPTURE_STEREO_EN
  localparam int unsigned FW = 2 * SAMPLE_W;
`else
  localparam int unsigned FW = SAMPLE_W;
`endif
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned BC_W  = $clog2(SAMPLE_W);
  localparam int unsigned PW    = FIFO_AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

  // Input synchronisers; the third bclk flop provides the edge detect
  logic bclk_s1, bclk_s2, bclk_s3;
  logic lrck_s1, lrck_s2, dat_s1, dat_s2;
  logic lrck_prev;

  always_ff @(posedge CLK or posedge pb_reset) begin
    if (pb_reset) begin
      bclk_s1 <= 1'b0; bclk_s2 <= 1'b0; bclk_s3 <= 1'b0;
      lrck_s1 <= 1'b0; lrck_s2 <= 1'b0;
      dat_s1  <= 1'b0; dat_s2  <= 1'b0;
    end else begin
      bclk_s1 <= aud_bclk;    bclk_s2 <= bclk_s1; bclk_s3 <= bclk_s2;
      lrck_s1 <= aud_adclrck; lrck_s2 <= lrck_s1;
      dat_s1  <= aud_adcdat;  dat_s2  <= dat_s1;
    end
  end

  logic bclk_rise_c, slot_c;
  assign bclk_rise_c = bclk_s2 & ~bclk_s3;
  // An LR change seen on a bit-clock rise is the I2S one-bit delay slot
  assign slot_c      = bclk_rise_c & (lrck_s2 ^ lrck_prev);

  state_t              state_q, state_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d, shifted_c;
  logic                push_q, push_d;
  logic                ferr_set_c;
`ifdef PB_ADC_CAPTURE_STEREO_EN
  logic                chan_q, chan_d;
  logic                have_left_q, have_left_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
`endif

  assign shifted_c = {shreg_q[SAMPLE_W-2:0], dat_s2};

  // Protocol state register
  always_ff @(posedge CLK or posedge pb_reset) begin
    if (pb_reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      lrck_prev   <= 1'b0;
`ifdef PB_ADC_CAPTURE_STEREO_EN
      chan_q      <= 1'b0;
      have_left_q <= 1'b0;
      left_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      if (bclk_rise_c) lrck_prev <= lrck_s2;
`ifdef PB_ADC_CAPTURE_STEREO_EN
      chan_q      <= chan_d;
      have_left_q <= have_left_d;
      left_q      <= left_d;
`endif
    end
  end

  // Next-state: frame alignment, deserialisation and push strobe
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    ferr_set_c  = 1'b0;
`ifdef PB_ADC_CAPTURE_STEREO_EN
    chan_d      = chan_q;
    have_left_d = have_left_q;
    left_d      = left_q;
`endif
    if (!enable) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
`ifdef PB_ADC_CAPTURE_STEREO_EN
      have_left_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (slot_c && !lrck_s2) begin
            state_d   = S_SHIFT;
            bit_cnt_d = '0;
`ifdef PB_ADC_CAPTURE_STEREO_EN
            chan_d      = 1'b0;
            have_left_d = 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          if (slot_c) begin
            // Short frame: drop the partial word and treat the edge as a fresh delay slot
            ferr_set_c = 1'b1;
            bit_cnt_d  = '0;
            state_d    = lrck_s2 ? S_WAIT : S_SHIFT;
`ifdef PB_ADC_CAPTURE_STEREO_EN
            chan_d      = 1'b0;
            have_left_d = 1'b0;
`endif
          end else if (bclk_rise_c) begin
            shreg_d   = shifted_c;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (bit_cnt_q == BC_W'(SAMPLE_W - 1)) begin
              state_d = S_WAIT;
`ifdef PB_ADC_CAPTURE_STEREO_EN
              if (!chan_q) begin
                left_d      = shifted_c;
                have_left_d = 1'b1;
              end else begin
                push_d      = 1'b1;
                have_left_d = 1'b0;
              end
`else
              push_d = 1'b1;
`endif
            end
          end
        end
        S_WAIT: begin
          if (slot_c) begin
            if (!lrck_s2) begin
              state_d   = S_SHIFT;
              bit_cnt_d = '0;
`ifdef PB_ADC_CAPTURE_STEREO_EN
              chan_d      = 1'b0;
              have_left_d = 1'b0;
`endif
            end else begin
`ifdef PB_ADC_CAPTURE_STEREO_EN
              // Right word is kept only when a complete left word precedes it
              if (have_left_q) begin
                state_d   = S_SHIFT;
                bit_cnt_d = '0;
                chan_d    = 1'b1;
              end else begin
                ferr_set_c = 1'b1;
              end
`endif
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO
  logic [FW-1:0]      mem [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [FW-1:0]      wdata_c, dout_d;
  logic               pop_ok_c, push_ok_c, ovf_set_c;
  logic [FIFO_AW-1:0] rd_idx_d;

`ifdef PB_ADC_CAPTURE_STEREO_EN
  assign wdata_c = {left_q, shreg_q};
`else
  assign wdata_c = shreg_q;
`endif

  assign pop_ok_c  = pop & ~fifo_empty;
  // A full FIFO still accepts a push when the same cycle frees a slot
  assign push_ok_c = push_q & (~fifo_full | pop_ok_c);
  assign ovf_set_c = push_q & ~push_ok_c;
  assign wr_ptr_d  = wr_ptr_q + PW'(push_ok_c);
  assign rd_ptr_d  = rd_ptr_q + PW'(pop_ok_c);
  assign rd_idx_d  = rd_ptr_d[FIFO_AW-1:0];
  // Bypass the write when the new head is the entry being written this cycle
  assign dout_d    = (push_ok_c && (wr_ptr_q[FIFO_AW-1:0] == rd_idx_d)) ? wdata_c : mem[rd_idx_d];

  always_ff @(posedge CLK) begin
    if (push_ok_c) mem[wr_ptr_q[FIFO_AW-1:0]] <= wdata_c;
  end

  always_ff @(posedge CLK or posedge pb_reset) begin
    if (pb_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_dout  <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push_ok_c || pop_ok_c) fifo_dout <= dout_d;
      fifo_empty <= (wr_ptr_d == rd_ptr_d);
      fifo_full  <= ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {FIFO_AW{1'b0}}});
      fifo_count <= wr_ptr_d - rd_ptr_d;
      // Set events take priority over clr_ovf
      if (ovf_set_c)       overflow <= 1'b1;
      else if (clr_ovf)    overflow <= 1'b0;
      if (ferr_set_c)      frame_err <= 1'b1;
      else if (clr_ovf)    frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pb_adc_capture.sv
// tb_pb_adc_capture: self-checking bench for pb_adc_capture.
// Drives I2S frames bit by bit, keeps a scoreboard queue of expected FIFO words and
// compares them as entries are popped. Builds for either setting of PB_ADC_CAPTURE_STEREO_EN.
module tb_pb_adc_capture;

`ifdef PB_ADC_CAPTURE_STEREO_EN
  localparam int unsigned FW = 32;
`else
  localparam int unsigned FW = 16;
`endif
  localparam int unsigned PAD = 3;

  logic          CLK, pb_reset, aud_bclk, aud_adclrck, aud_adcdat;
  logic          enable, pop, clr_ovf;
  logic [FW-1:0] fifo_dout;
  logic          fifo_empty, fifo_full, overflow, frame_err;
  logic [4:0]    fifo_count;

  pb_adc_capture #(.SAMPLE_W(16), .FIFO_AW(4)) dut (
    .CLK(CLK), .pb_reset(pb_reset), .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
    .aud_adcdat(aud_adcdat), .enable(enable), .pop(pop), .clr_ovf(clr_ovf),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [FW-1:0] exp_q[$];

  typedef struct {
    logic [15:0]   left;
    logic [15:0]   right;
    logic [FW-1:0] want;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic logic [FW-1:0] exp_word(input logic [15:0] l, input logic [15:0] r);
`ifdef PB_ADC_CAPTURE_STEREO_EN
    return {l, r};
`else
    return FW'(l) | FW'(r & 16'h0000);
`endif
  endfunction

  // One bit period: data and LR change while bclk is low; bclk rises on a CLK negedge.
  // pop_here raises pop for the cycle in which the push triggered by this rise lands.
  task automatic send_bit(input logic lr, input logic d, input bit pop_here);
    logic [FW-1:0] e;
    @(negedge CLK);
    aud_bclk = 1'b0; aud_adclrck = lr; aud_adcdat = d;
    repeat (4) @(negedge CLK);
    aud_bclk = 1'b1;
    repeat (3) @(negedge CLK);
    if (pop_here) begin
      e = exp_q.pop_front();
      chk("pop_at_full_head", 32'(fifo_dout), 32'(e));
      pop = 1'b1;
    end
    @(negedge CLK);
    pop = 1'b0;
  endtask

  task automatic send_channel(input logic lr, input logic [15:0] w, input int ndata, input bit pop_last);
    send_bit(lr, 1'b0, 1'b0);
    for (int i = 0; i < ndata; i++) send_bit(lr, w[4'(15 - i)], pop_last && (i == ndata - 1));
    for (int i = 0; i < int'(PAD); i++) send_bit(lr, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit pop_last);
`ifdef PB_ADC_CAPTURE_STEREO_EN
    send_channel(1'b0, l, 16, 1'b0);
    send_channel(1'b1, r, 16, pop_last);
`else
    send_channel(1'b0, l, 16, pop_last);
    send_channel(1'b1, r, 16, 1'b0);
`endif
  endtask

  task automatic do_pop(input string name);
    logic [FW-1:0] e;
    e = exp_q.pop_front();
    @(negedge CLK);
    chk(name, 32'(fifo_dout), 32'(e));
    pop = 1'b1;
    @(negedge CLK);
    pop = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge CLK); clr_ovf = 1'b1;
    @(negedge CLK); clr_ovf = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
`ifdef PB_ADC_CAPTURE_STEREO_EN
    vecs[0] = '{left: 16'hA5C3, right: 16'h1234, want: 32'hA5C31234};
    vecs[1] = '{left: 16'h1111, right: 16'h2222, want: 32'h11112222};
    vecs[2] = '{left: 16'h8001, right: 16'hFFFF, want: 32'h8001FFFF};
`else
    vecs[0] = '{left: 16'hA5C3, right: 16'h1234, want: 16'hA5C3};
    vecs[1] = '{left: 16'h1111, right: 16'h2222, want: 16'h1111};
    vecs[2] = '{left: 16'h8001, right: 16'hFFFF, want: 16'h8001};
`endif
    pb_reset = 1'b1; aud_bclk = 1'b0; aud_adclrck = 1'b0; aud_adcdat = 1'b0;
    enable = 1'b0; pop = 1'b0; clr_ovf = 1'b0;
    repeat (5) @(negedge CLK);
    pb_reset = 1'b0;
    @(negedge CLK);

    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_dout", 32'(fifo_dout), 32'd0);

    // Preamble on the right channel so the first left word has a visible delay slot
    enable = 1'b1;
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);

    // Single-frame captures
    for (int i = 0; i < 3; i++) begin
      send_frame(vecs[i].left, vecs[i].right, 1'b0);
      exp_q.push_back(vecs[i].want);
      chk("single_count", 32'(fifo_count), 32'd1);
      do_pop("single_dout");
      chk("single_empty_after_pop", 32'(fifo_empty), 32'd1);
    end

    // Fill past capacity without popping: the 17th word is dropped
    for (int i = 1; i <= 17; i++) begin
      send_frame(16'(i), 16'hF000 | 16'(i), 1'b0);
      if (exp_q.size() < 16) exp_q.push_back(exp_word(16'(i), 16'hF000 | 16'(i)));
    end
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_count", 32'(fifo_count), 32'd16);
    chk("fill_overflow", 32'(overflow), 32'd1);
    pulse_clr;
    chk("clr_overflow", 32'(overflow), 32'd0);
    repeat (16) do_pop("fill_drain");
    chk("drain_empty", 32'(fifo_empty), 32'd1);

    // Pop while empty is ignored
    @(negedge CLK); pop = 1'b1;
    @(negedge CLK); pop = 1'b0;
    @(negedge CLK);
    chk("empty_pop_count", 32'(fifo_count), 32'd0);
    chk("empty_pop_empty", 32'(fifo_empty), 32'd1);

    // Push coinciding with a pop at full: count unchanged, no overflow
    for (int i = 0; i < 16; i++) begin
      send_frame(16'h0100 + 16'(i), 16'h0700 + 16'(i), 1'b0);
      exp_q.push_back(exp_word(16'h0100 + 16'(i), 16'h0700 + 16'(i)));
    end
    chk("pp_full_before", 32'(fifo_full), 32'd1);
    send_frame(16'h0200, 16'h0300, 1'b1);
    exp_q.push_back(exp_word(16'h0200, 16'h0300));
    chk("pp_count", 32'(fifo_count), 32'd16);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_full_after", 32'(fifo_full), 32'd1);
    repeat (16) do_pop("pp_drain");
    chk("pp_drain_empty", 32'(fifo_empty), 32'd1);

    // Short left frame: LR toggles before 16 bits are in
    send_channel(1'b0, 16'hDEAD, 9, 1'b0);
    send_channel(1'b1, 16'h7777, 16, 1'b0);
    chk("short_frame_err", 32'(frame_err), 32'd1);
    chk("short_no_push", 32'(fifo_count), 32'd0);
    send_frame(16'hBEEF, 16'h4321, 1'b0);
    exp_q.push_back(exp_word(16'hBEEF, 16'h4321));
    chk("short_next_count", 32'(fifo_count), 32'd1);
    do_pop("short_next_dout");
    pulse_clr;
    chk("clr_frame_err", 32'(frame_err), 32'd0);

    // Reset in the middle of a word with one entry buffered
    send_frame(16'h5A5A, 16'h0000, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    repeat (5) send_bit(1'b0, 1'b1, 1'b0);
    @(negedge CLK); pb_reset = 1'b1;
    @(negedge CLK);
    chk("midrst_empty", 32'(fifo_empty), 32'd1);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_full", 32'(fifo_full), 32'd0);
    exp_q.delete();
    enable = 1'b0;
    @(negedge CLK); pb_reset = 1'b0;

    // Disabled capture with the bit clock running
    send_frame(16'h1357, 16'h2468, 1'b0);
    send_frame(16'h9BDF, 16'hACE0, 1'b0);
    chk("disabled_count", 32'(fifo_count), 32'd0);
    chk("disabled_empty", 32'(fifo_empty), 32'd1);

    // Re-enable: capture resumes from IDLE on the next left slot
    enable = 1'b1;
    send_frame(16'hC0DE, 16'h0BAD, 1'b0);
    exp_q.push_back(exp_word(16'hC0DE, 16'h0BAD));
    chk("reenable_count", 32'(fifo_count), 32'd1);
    do_pop("reenable_dout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
